// File: rtl/follower_pkg.sv
// -----------------------------------------------------------------------------
// follower_pkg
// Shared definitions for the Follower's serial front ends.
//   bc_state_t  : barcode frame decoder state encoding
//   BC_BITS     : data bits per barcode frame (MSB first)
//   BC_ID_MASK  : upper-bit mask; a frame is accepted only when these bits are 0
//   bc_id_ok()  : acceptance test for a fully shifted frame
// -----------------------------------------------------------------------------
package follower_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_FALL = 3'd2,
        BIT       = 3'd3,
        DONE      = 3'd4
    } bc_state_t;

    localparam int          BC_BITS    = 8;
    localparam logic [1:0]  BC_ID_MASK = 2'b11;

    // A frame carries a valid station ID only when its two top bits are clear.
    function automatic logic bc_id_ok(input logic [7:0] frame);
        return ((frame[7:6] & BC_ID_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/bc_sync_edge.sv
// -----------------------------------------------------------------------------
// bc_sync_edge
// Two-flop synchronizer for an asynchronous, idle-high serial line followed by
// a one-flop delay used for edge detection. All flops reset to 1 so that the
// idle line never produces a spurious edge out of reset.
// Ports:
//   clk   in  : system clock
//   rst   in  : synchronous active-high reset
//   din   in  : raw asynchronous serial input
//   bc_s  out : synchronized line level
//   fall  out : one-cycle pulse on a synchronized high->low transition
//   rise  out : one-cycle pulse on a synchronized low->high transition
// -----------------------------------------------------------------------------
module bc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic bc_s,
    output logic fall,
    output logic rise
);

    logic bc_meta_r;
    logic bc_sync_r;
    logic bc_p_r;

    // Synchronizer chain plus previous-level flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_meta_r <= 1'b1;
            bc_sync_r <= 1'b1;
            bc_p_r    <= 1'b1;
        end else begin
            bc_meta_r <= din;
            bc_sync_r <= bc_meta_r;
            bc_p_r    <= bc_sync_r;
        end
    end

    assign bc_s = bc_sync_r;
    assign fall = bc_p_r & ~bc_sync_r;
    assign rise = ~bc_p_r & bc_sync_r;

endmodule

// File: rtl/barcode_reader.sv
// -----------------------------------------------------------------------------
// barcode_reader
// Decodes the serial barcode line into an 8-bit station ID. The start-bit low
// time is measured and kept as the timing reference; each data bit is sampled
// that many cycles after its falling edge, which lands midway between the
// short (1) and long (0) low times. Frames with a non-zero upper two bits are
// dropped. ID_vld is sticky until clr_ID_vld; a simultaneous set wins.
// Ports:
//   clk         in  : system clock
//   rst         in  : synchronous active-high reset
//   BC          in  : raw asynchronous barcode line (idles high)
//   clr_ID_vld  in  : clears ID_vld
//   ID          out : last accepted station ID (registered)
//   ID_vld      out : sticky new-ID flag (registered)
// -----------------------------------------------------------------------------
module barcode_reader
    import follower_pkg::*;
#(
    parameter int CNT_W   = 22,
    parameter int MIN_REF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_REF_C = CNT_W'(MIN_REF);
    localparam logic [3:0]       BIT_LAST  = 4'(BC_BITS - 1);

    logic             bc_s;
    logic             bc_fall_s;
    logic             bc_rise_s;

    bc_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] ref_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic [7:0]       id_r;
    logic             id_vld_r;

    bc_sync_edge u_bc_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (BC),
        .bc_s (bc_s),
        .fall (bc_fall_s),
        .rise (bc_rise_s)
    );

    // Frame decoder FSM with its counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            ref_r     <= {CNT_W{1'b0}};
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            id_r      <= 8'h00;
            id_vld_r  <= 1'b0;
        end else begin
            // Clear first so that an acceptance in DONE below overrides it.
            if (clr_ID_vld) begin
                id_vld_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    bit_cnt_r <= 4'd0;
                    if (bc_fall_s) begin
                        state_r <= START;
                    end
                end

                START: begin
                    if (bc_rise_s) begin
                        // Too-short lows are treated as line glitches.
                        if (cnt_r >= MIN_REF_C) begin
                            ref_r   <= cnt_r;
                            state_r <= WAIT_FALL;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= IDLE;
                    end else if (!bc_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                WAIT_FALL: begin
                    if (bc_fall_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= BIT;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                BIT: begin
                    // cnt never passes ref here, and ref is below CNT_MAX,
                    // so this increment cannot wrap.
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == ref_r) begin
                        shift_r   <= {shift_r[6:0], bc_s};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= WAIT_FALL;
                        end
                    end
                end

                DONE: begin
                    if (bc_id_ok(shift_r)) begin
                        id_r     <= shift_r;
                        id_vld_r <= 1'b1;
                    end
                    state_r <= IDLE;
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ID     = id_r;
    assign ID_vld = id_vld_r;

endmodule

// File: tb/tb_barcode_reader.sv
// -----------------------------------------------------------------------------
// tb_barcode_reader
// Drives barcode frames (start low period/2, high period/2; each bit low
// period/4 for 1 or 3*period/4 for 0, rest of the period high) into two
// decoders: one with the default counter width and one with CNT_W=10 for the
// timeout case. Expected ID/ID_vld come from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_barcode_reader;

    logic       clk;
    logic       rst;
    logic       bc;
    logic       hide_main;
    logic       clr_ID_vld;
    logic       bc_main;
    logic [7:0] id_main;
    logic       vld_main;
    logic [7:0] id_10;
    logic       vld_10;

    int n_checks;
    int n_errors;

    // Frame-level reference state for each decoder.
    logic [7:0] exp_id_main;
    logic       exp_vld_main;
    logic [7:0] exp_id_10;
    logic       exp_vld_10;

    // ID_vld high-cycle counters used for the set-vs-clear case.
    logic mon_en;
    int   hi_main;
    int   hi_10;

    assign bc_main = bc | hide_main;

    barcode_reader dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (bc_main),
        .clr_ID_vld (clr_ID_vld),
        .ID         (id_main),
        .ID_vld     (vld_main)
    );

    barcode_reader #(.CNT_W(10), .MIN_REF(4)) dut10 (
        .clk        (clk),
        .rst        (rst),
        .BC         (bc),
        .clr_ID_vld (clr_ID_vld),
        .ID         (id_10),
        .ID_vld     (vld_10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (vld_main) hi_main = hi_main + 1;
            if (vld_10)   hi_10   = hi_10 + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq($sformatf("%s.id", tag),    {24'd0, id_main},  {24'd0, exp_id_main});
        check_eq($sformatf("%s.vld", tag),   {31'd0, vld_main}, {31'd0, exp_vld_main});
        check_eq($sformatf("%s.id10", tag),  {24'd0, id_10},    {24'd0, exp_id_10});
        check_eq($sformatf("%s.vld10", tag), {31'd0, vld_10},   {31'd0, exp_vld_10});
    endtask

    task automatic line_low_high(input int low, input int high);
        bc = 1'b0;
        repeat (low) @(negedge clk);
        bc = 1'b1;
        repeat (high) @(negedge clk);
    endtask

    // Send the start bit and the first nbits data bits of id.
    task automatic send_frame(input int p, input logic [7:0] id, input int nbits);
        int lo;
        line_low_high(p / 2, p - p / 2);
        for (int i = 0; i < nbits; i++) begin
            lo = id[7 - i] ? (p / 4) : ((3 * p) / 4);
            line_low_high(lo, p - lo);
        end
    endtask

    // Model: a complete frame is accepted when its ID is below 0x40.
    task automatic model_frame(input logic [7:0] id, input logic both);
        if (id < 8'h40) begin
            exp_id_main  = id;
            exp_vld_main = 1'b1;
            if (both) begin
                exp_id_10  = id;
                exp_vld_10 = 1'b1;
            end
        end
    endtask

    task automatic frame_and_check(input string tag, input int p, input logic [7:0] id);
        send_frame(p, id, 8);
        repeat (10) @(negedge clk);
        model_frame(id, 1'b1);
        check_all(tag);
    endtask

    task automatic pulse_clr();
        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        exp_vld_main = 1'b0;
        exp_vld_10   = 1'b0;
    endtask

    initial begin
        logic [7:0] rid;
        int         rp;

        n_checks   = 0;
        n_errors   = 0;
        bc         = 1'b1;
        hide_main  = 1'b0;
        clr_ID_vld = 1'b0;
        mon_en     = 1'b0;
        hi_main    = 0;
        hi_10      = 0;
        rst        = 1'b1;
        exp_id_main = 8'h00; exp_vld_main = 1'b0;
        exp_id_10   = 8'h00; exp_vld_10   = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_all("reset");

        // Basic decode and rejection of a frame with upper bits set.
        frame_and_check("id25", 32'h20A, 8'h25);
        frame_and_check("rejC5", 32'h20A, 8'hC5);

        // Clear, then a fresh accept.
        frame_and_check("id3F", 32'h80, 8'h3F);
        pulse_clr();
        check_all("clr");
        frame_and_check("id01", 32'h80, 8'h01);

        // Clear held through the acceptance: set wins for exactly one cycle.
        pulse_clr();
        check_all("clr2");
        clr_ID_vld = 1'b1;
        hi_main = 0;
        hi_10   = 0;
        mon_en  = 1'b1;
        send_frame(32'h40, 8'h07, 8);
        repeat (10) @(negedge clk);
        mon_en     = 1'b0;
        clr_ID_vld = 1'b0;
        model_frame(8'h07, 1'b1);
        exp_vld_main = 1'b0;
        exp_vld_10   = 1'b0;
        check_eq("setwins.hi", hi_main, 1);
        check_eq("setwins.hi10", hi_10, 1);
        check_all("setwins");

        // Two-cycle glitch is ignored; a short-period frame then decodes.
        line_low_high(2, 40);
        check_all("glitch");
        frame_and_check("id12", 32'h40, 8'h12);

        // Start bit then a long high: only the narrow counter times out.
        hide_main = 1'b1;
        line_low_high(32'h20, 1100);
        hide_main = 1'b0;
        check_all("timeout");
        frame_and_check("id2A", 32'h40, 8'h2A);

        // Reset in the middle of a frame, then resend.
        send_frame(32'h40, 8'h33, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_id_main = 8'h00; exp_vld_main = 1'b0;
        exp_id_10   = 8'h00; exp_vld_10   = 1'b0;
        repeat (5) @(negedge clk);
        check_all("midrst");
        frame_and_check("id33", 32'h40, 8'h33);

        // Randomized frames, periods, IDs and clears.
        for (int k = 0; k < 12; k++) begin
            rp  = $urandom_range(64, 256);
            rid = 8'($urandom);
            if ($urandom_range(0, 1) == 0) rid[7:6] = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                check_all($sformatf("rclr%0d", k));
            end
            frame_and_check($sformatf("rnd%0d", k), rp, rid);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
